// File: rtl/snap_ctrl_pkg.sv
// Shared definitions for the snapshot capture controller: FSM encoding,
// status word bit positions and ctrl word bit positions.
package snap_ctrl_pkg;

  // Capture sequencer states; StDelay is only reachable when SNAP_OFFSET_EN is defined
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArmed   = 3'd1,
    StDelay   = 3'd2,
    StCapture = 3'd3,
    StDone    = 3'd4
  } snap_state_e;

  // Status word flag positions
  localparam int unsigned STAT_DONE  = 31;
  localparam int unsigned STAT_ARMED = 30;
  localparam int unsigned STAT_CAPT  = 29;

  // Ctrl word bit positions
  localparam int unsigned CTRL_ARM      = 0;
  localparam int unsigned CTRL_TRIG_IMM = 1;

endpackage

// File: rtl/snap_edge_det.sv
// Registered rise/fall detector for a single level signal.
// The history register clears on reset, so a level that is already high
// when reset releases is reported as a rising edge.
module snap_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  // One-cycle history of the watched level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture sequencer: arm, wait for trigger, burst 2**ADDR_W samples
// into the snapshot BRAM, then flag done in the status word.
// Optional feature macro: SNAP_OFFSET_EN adds a post-trigger skip of
// `offset` valid samples (DELAY state) before capture begins.
module snap_capture_ctrl
  import snap_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              trig,
  input  logic [15:0]       offset,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       status
);

  // Count value that marks a full buffer; count never goes beyond it
  localparam logic [ADDR_W:0] CountFull = {1'b1, {ADDR_W{1'b0}}};

  snap_state_e       state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              write;
  logic              arm_rise, arm_fall;
  logic [31:0]       status_q, status_d;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_data_q;
  logic              bram_we_q;

`ifdef SNAP_OFFSET_EN
  logic [15:0]       skip_q, skip_d;
`endif

  // Only the arm and trig_imm bits of ctrl carry meaning
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl[31:2];

`ifndef SNAP_OFFSET_EN
  logic unused_offset;
  assign unused_offset = ^offset;
`endif

  snap_edge_det u_arm_edge (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .sig   (ctrl[CTRL_ARM]),
    .rise  (arm_rise),
    .fall  (arm_fall)
  );

  // Next-state, write decision and count update
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    write   = 1'b0;
`ifdef SNAP_OFFSET_EN
    skip_d  = skip_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (arm_rise) begin
          count_d = '0;
          state_d = ctrl[CTRL_TRIG_IMM] ? StCapture : StArmed;
        end
      end

      StArmed: begin
        // Disarm wins over a coincident trigger
        if (arm_fall) begin
          state_d = StIdle;
        end else if (din_valid && trig) begin
`ifdef SNAP_OFFSET_EN
          if (offset == 16'd0) begin
            write   = 1'b1;
            state_d = StCapture;
          end else begin
            // Trigger sample is the first discarded one
            skip_d  = offset - 16'd1;
            state_d = StDelay;
          end
`else
          write   = 1'b1;
          state_d = StCapture;
`endif
        end
      end

`ifdef SNAP_OFFSET_EN
      StDelay: begin
        if (arm_fall) begin
          state_d = StIdle;
        end else if (din_valid) begin
          if (skip_q == 16'd0) begin
            write   = 1'b1;
            state_d = StCapture;
          end else begin
            skip_d = skip_q - 16'd1;
          end
        end
      end
`endif

      StCapture: begin
        // A sample coincident with the disarm is still kept
        if (din_valid) begin
          write = 1'b1;
        end
        if (arm_fall) begin
          state_d = StDone;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (write) begin
      count_d = count_q + 1'b1;
      if (count_d == CountFull) begin
        state_d = StDone;
      end
    end
  end

  // Status word mirrors the post-edge state and count
  always_comb begin
    status_d             = '0;
    status_d[STAT_DONE]  = (state_d == StDone);
    status_d[STAT_ARMED] = (state_d == StArmed) || (state_d == StDelay);
    status_d[STAT_CAPT]  = (state_d == StCapture);
    status_d[ADDR_W:0]   = count_d;
  end

  // FSM, counter and status registers
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

`ifdef SNAP_OFFSET_EN
  // Remaining samples to discard after the trigger
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      skip_q <= '0;
    end else begin
      skip_q <= skip_d;
    end
  end
`endif

  // BRAM write port, one cycle behind the qualifying sample
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
    end else begin
      bram_we_q <= write;
      if (write) begin
        bram_addr_q <= count_q[ADDR_W-1:0];
        bram_data_q <= din;
      end
    end
  end

  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_data = bram_data_q;
  assign status    = status_q;

endmodule
